// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht
//
// Branch history table of 2-bit saturating counters for the fetch stage.
// The read path is combinational from fetch_pc_i. The execute stage writes
// back one resolved outcome per cycle. All table state is gated by the
// pipeline stall enable.
//
// Optional feature macro: BHT_BYPASS_EN
//   defined   - a same-cycle update to the entry being read is forwarded to
//               predict_state_o / predict_taken_o.
//   undefined - the read path shows the pre-update table value.
//   Table contents are identical in both builds.
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_i            synchronous active-high reset, sets every entry to 01
//   enable_i         stall gate; low freezes the table and ignores updates
//   fetch_pc_i       PC of the instruction being fetched
//   predict_taken_o  predicted direction (predict_state_o[1])
//   predict_state_o  raw 2-bit counter for fetch_pc_i, feeds the IF/ID register
//   update_valid_i   execute stage has a resolved conditional branch
//   update_pc_i      PC of the resolved branch
//   update_taken_i   resolved direction, 1 = taken
//
// Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.

module branch_predictor_bht #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned PC_W  = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    input  logic [PC_W-1:0] fetch_pc_i,
    output logic            predict_taken_o,
    output logic [1:0]      predict_state_o,
    input  logic            update_valid_i,
    input  logic [PC_W-1:0] update_pc_i,
    input  logic            update_taken_i
);

    localparam int unsigned Entries = 1 << IDX_W;

    logic [1:0]       bht_q [Entries];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_cur;
    logic [1:0]       upd_cnt_d;
    logic             upd_en;

    // Instructions are 2-byte aligned, so PC bit 0 carries no information.
    assign fetch_idx = fetch_pc_i[IDX_W:1];
    assign upd_idx   = update_pc_i[IDX_W:1];
    assign upd_en    = update_valid_i && enable_i;
    assign upd_cur   = bht_q[upd_idx];

    // Saturating next value for the entry being updated; no wrap-around.
    always_comb begin
        upd_cnt_d = upd_cur;
        if (update_taken_i) begin
            if (upd_cur != 2'b11) begin
                upd_cnt_d = upd_cur + 2'd1;
            end
        end else begin
            if (upd_cur != 2'b00) begin
                upd_cnt_d = upd_cur - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Entries; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (upd_en) begin
            bht_q[upd_idx] <= upd_cnt_d;
        end
    end

    always_comb begin
        predict_state_o = bht_q[fetch_idx];
`ifdef BHT_BYPASS_EN
        // Forward the in-flight update so fetch sees the trained value now.
        if (upd_en && (fetch_idx == upd_idx)) begin
            predict_state_o = upd_cnt_d;
        end
`else
`endif
        predict_taken_o = predict_state_o[1];
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed self-checking bench for branch_predictor_bht (default IDX_W/PC_W).

module tb_branch_predictor_bht;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] fetch_pc;
    logic        predict_taken;
    logic [1:0]  predict_state;
    logic        update_valid;
    logic [15:0] update_pc;
    logic        update_taken;

    int n_checks;
    int n_fail;

    branch_predictor_bht #(
        .IDX_W(4),
        .PC_W (16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .fetch_pc_i     (fetch_pc),
        .predict_taken_o(predict_taken),
        .predict_state_o(predict_state),
        .update_valid_i (update_valid),
        .update_pc_i    (update_pc),
        .update_taken_i (update_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int pc = 0; pc <= 16'h1E; pc += 2) begin
            fetch_pc = 16'(pc);
            #1;
            n_checks++;
            if (predict_state !== 2'b01) begin
                n_fail++;
                $display("FAIL reset_state pc=%h got=%b exp=01", fetch_pc, predict_state);
            end
            n_checks++;
            if (predict_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_taken pc=%h got=%b exp=0", fetch_pc, predict_taken);
            end
        end
    endtask

    task automatic test_sat_up();
        logic [1:0] exp_seq [4];
        exp_seq = '{2'b10, 2'b11, 2'b11, 2'b11};
        update_valid = 1'b1;
        update_pc    = 16'h0004;
        update_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) update_valid = 1'b0;
            fetch_pc = 16'h0004;
            #1;
            n_checks++;
            if (predict_state !== exp_seq[i] || predict_taken !== exp_seq[i][1]) begin
                n_fail++;
                $display("FAIL sat_up step=%0d got=%b/%b exp=%b", i, predict_state,
                         predict_taken, exp_seq[i]);
            end
        end
        fetch_pc = 16'h0006;
        #1;
        n_checks++;
        if (predict_state !== 2'b01) begin
            n_fail++;
            $display("FAIL sat_up_neighbour got=%b exp=01", predict_state);
        end
    endtask

    task automatic test_sat_down_alias();
        logic [1:0] exp_seq [4];
        exp_seq = '{2'b10, 2'b01, 2'b00, 2'b00};
        update_valid = 1'b1;
        update_pc    = 16'h0008;
        update_taken = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fetch_pc = 16'h0008;
        #1;
        n_checks++;
        if (predict_state !== 2'b11) begin
            n_fail++;
            $display("FAIL sat_down_train got=%b exp=11", predict_state);
        end
        update_pc    = 16'h0028;
        update_taken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) update_valid = 1'b0;
            fetch_pc = 16'h0008;
            #1;
            n_checks++;
            if (predict_state !== exp_seq[i] || predict_taken !== exp_seq[i][1]) begin
                n_fail++;
                $display("FAIL sat_down step=%0d got=%b/%b exp=%b", i, predict_state,
                         predict_taken, exp_seq[i]);
            end
        end
    endtask

    task automatic test_stall();
        enable       = 1'b0;
        update_valid = 1'b1;
        update_pc    = 16'h0002;
        update_taken = 1'b1;
        fetch_pc     = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (predict_state !== 2'b01) begin
                n_fail++;
                $display("FAIL stall_hold step=%0d got=%b exp=01", i, predict_state);
            end
        end
        enable = 1'b1;
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        #1;
        n_checks++;
        if (predict_state !== 2'b10 || predict_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release got=%b/%b exp=10/1", predict_state, predict_taken);
        end
    endtask

    task automatic test_collision();
        logic [1:0] exp_same;
`ifdef BHT_BYPASS_EN
        exp_same = 2'b10;
`else
        exp_same = 2'b01;
`endif
        fetch_pc     = 16'h000C;
        update_pc    = 16'h000C;
        update_taken = 1'b1;
        update_valid = 1'b1;
        #1;
        n_checks++;
        if (predict_state !== exp_same) begin
            n_fail++;
            $display("FAIL collision_same_cycle got=%b exp=%b", predict_state, exp_same);
        end
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        #1;
        n_checks++;
        if (predict_state !== 2'b10) begin
            n_fail++;
            $display("FAIL collision_next_cycle got=%b exp=10", predict_state);
        end
    endtask

    task automatic test_reset_mid();
        update_valid = 1'b1;
        update_pc    = 16'h0010;
        update_taken = 1'b1;
        fetch_pc     = 16'h0010;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (predict_state !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_mid_train got=%b exp=11", predict_state);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        update_valid = 1'b0;
        #1;
        n_checks++;
        if (predict_state !== 2'b01 || predict_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_entry got=%b/%b exp=01/0", predict_state, predict_taken);
        end
        fetch_pc = 16'h0004;
        #1;
        n_checks++;
        if (predict_state !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_mid_other got=%b exp=01", predict_state);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b0;
        enable       = 1'b1;
        fetch_pc     = '0;
        update_valid = 1'b0;
        update_pc    = '0;
        update_taken = 1'b0;
        test_reset();
        test_sat_up();
        test_sat_down_alias();
        test_stall();
        test_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
